// File: rtl/csa_add_arbiter.sv
// Two-requester round-robin arbiter sharing one carry-skip adder.
// Multi-beat operations lock the grant and chain the carry between beats.

module csa_skip_adder #(
    parameter int WIDTH = 8,
    parameter int BLK   = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    localparam int NB = (WIDTH + BLK - 1) / BLK;

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic             c;
    logic             bin;
    logic             r;
    logic             pall;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    // Ripple within a block; a fully-propagating block passes its carry-in
    // straight through the skip mux.
    always_comb begin
        sum_o = '0;
        c     = cin_i;
        bin   = 1'b0;
        r     = 1'b0;
        pall  = 1'b0;
        for (int k = 0; k < NB; k++) begin
            bin  = c;
            r    = c;
            pall = 1'b1;
            for (int j = 0; j < BLK; j++) begin
                if (k * BLK + j < WIDTH) begin
                    sum_o[k*BLK+j] = p[k*BLK+j] ^ r;
                    r    = g[k*BLK+j] | (p[k*BLK+j] & r);
                    pall = pall & p[k*BLK+j];
                end
            end
            c = pall ? bin : r;
        end
        cout_o = c;
    end
endmodule

module csa_add_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req_sub,
    input  logic [1:0]       req_last,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_last,
    output logic             rsp_ovf,
    output logic             busy
);
    localparam int CW = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            rr_q, rr_d;
    logic            carry_q, carry_d;
    logic            sub_q, sub_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            en_q;

    logic            valid_q;
    logic            id_q;
    logic [WIDTH-1:0] sum_q;
    logic            cout_q;
    logic            last_q;
    logic            ovf_q;

    logic [1:0]       grant;
    logic             w;
    logic             first;
    logic             can_take;
    logic             accept;
    logic             sub_eff;
    logic             cin;
    logic             cout;
    logic             at_max;
    logic             rel;
    logic [CW-1:0]    cnt_inc;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;

    // Pick the granted requester: round-robin in IDLE, owner while locked.
    always_comb begin
        grant = 2'b00;
        w     = rr_q;
        unique case (state_q)
            IDLE: begin
                w        = req_valid[rr_q] ? rr_q : ~rr_q;
                grant[w] = req_valid[w] & en_q;
            end
            LOCK0: begin
                w     = 1'b0;
                grant = 2'b01;
            end
            LOCK1: begin
                w     = 1'b1;
                grant = 2'b10;
            end
            default: ;
        endcase
    end

    assign first     = (state_q == IDLE);
    assign can_take  = ~valid_q | rsp_ready;
    assign req_ready = grant & {2{can_take}};
    assign accept    = |(req_valid & req_ready);

    assign a_sel   = w ? req1_a : req0_a;
    assign b_sel   = w ? req1_b : req0_b;
    assign sub_eff = first ? req_sub[w] : sub_q;
    assign cin     = first ? req_sub[w] : carry_q;
    assign b_eff   = sub_eff ? ~b_sel : b_sel;

    assign cnt_inc = first ? CW'(1) : cnt_q + CW'(1);
    assign at_max  = (cnt_inc == MAXC);
    assign rel     = req_last[w] | at_max;

    csa_skip_adder #(
        .WIDTH (WIDTH),
        .BLK   (4)
    ) u_add (
        .a_i    (a_sel),
        .b_i    (b_eff),
        .cin_i  (cin),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // Next-state: lock on a non-final first beat, release on last or watchdog.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        if (accept) begin
            if (first) begin
                sub_d = req_sub[w];
                rr_d  = ~w;
            end
            if (rel) begin
                state_d = IDLE;
                carry_d = 1'b0;
                cnt_d   = '0;
            end else begin
                state_d = w ? LOCK1 : LOCK0;
                carry_d = cout;
                cnt_d   = cnt_inc;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
            en_q    <= 1'b1;
        end
    end

    // Single-entry output register; load and drain may happen together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            id_q    <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            id_q    <= w;
            sum_q   <= sum;
            cout_q  <= cout;
            last_q  <= req_last[w];
            ovf_q   <= at_max;
        end else if (rsp_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_last  = last_q;
    assign rsp_ovf   = ovf_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: doc/csa_add_arbiter.md
Name: csa_add_arbiter

Overview:
- Shares one 8-bit carry-skip adder datapath between two requesters, so multi-byte (multi-precision) add/subtract operations can time-share a single adder.
- Round-robin arbitration at operation granularity; grant stays locked to one requester until its last beat.
- Carry is chained beat to beat inside the controller; each beat's result is registered and returned with the owner's ID.
- Sits between the top-level I/O glue and the carry-skip adder core. The adder is instantiated internally, with its carry-in driven by this block.

Parameters:
- WIDTH, 8, operand/sum width per beat. Only 8 is verified.
- MAX_BEATS, 16, maximum beats per locked operation. A watchdog forces release after this many beats.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  2  per-requester beat valid (bit i = requester i)
- req_ready  output  2  per-requester beat accepted this cycle
- req0_a, req0_b  input  WIDTH each  requester 0 operands
- req1_a, req1_b  input  WIDTH each  requester 1 operands
- req_sub  input  2  per-requester subtract flag; sampled on first beat only
- req_last  input  2  per-requester final-beat marker
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  1  requester owning the result
- rsp_sum  output  WIDTH  beat sum
- rsp_cout  output  1  carry out of this beat
- rsp_last  output  1  echoes req_last of this beat
- rsp_ovf  output  1  watchdog forced release on this beat
- busy  output  1  a locked operation is in progress

Behaviour:
- Reset (async, rst_n low):
  - FSM = IDLE; rr_ptr = 0; carry register = 0; beat counter = 0.
  - All outputs 0: rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last, rsp_ovf, busy, req_ready.
- FSM states: IDLE, LOCK0, LOCK1.
  - IDLE: winner = rr_ptr if its req_valid is set, else the other valid requester. The first beat of the winner is accepted immediately.
  - On an accepted first beat:
    - sub_r = req_sub[w].
    - cin = sub_r.
    - Enter LOCK_w, unless that beat has req_last, in which case stay in IDLE.
    - rr_ptr = ~w.
  - LOCK_w: only requester w may be granted. cin = carry register. The other requester's req_ready = 0.
  - Leave LOCK_w to IDLE when an accepted beat has req_last, or when the beat counter reaches MAX_BEATS.
- Beat acceptance:
  - req_ready[w] = grant_w & (~rsp_valid | rsp_ready). The output register holds at most one result.
  - Accept = req_valid[w] & req_ready[w].
  - Combinational only from registered state and rsp_ready. No dependence on req_valid except arbitration selection.
- Datapath:
  - b_eff = sub_r ? ~b : b.
  - {cout, sum} = a + b_eff + cin, computed by the carry-skip adder.
  - Carry register updates with cout on each accepted beat; it is cleared on release.
- Latency: result is registered and presented one cycle after acceptance (rsp_valid high the next cycle).
  - rsp_* hold stable while rsp_valid & ~rsp_ready.
  - rsp_valid drops after the handshake unless a new beat was accepted in the same cycle.
- Watchdog:
  - Beat counter increments per accepted beat in LOCK.
  - At MAX_BEATS the beat is tagged rsp_ovf = 1, treated as last, and the lock is released.
  - A later beat from the same requester starts a new operation with cin = req_sub.
- busy = FSM != IDLE.
- Simultaneous events:
  - Both requesters valid in IDLE: rr_ptr wins.
  - A requester deasserting valid mid-operation keeps the lock. There is no timeout other than the beat count.
  - Transfer into and out of the output register in the same cycle is allowed, giving full throughput.
- Reset mid-operation: lock, carry and the pending result are discarded. No response is emitted.

Test Plan:
- Single beat: req0 a=0x3C, b=0x0F, last=1 -> next cycle rsp_valid=1, id=0, sum=0x4B, cout=0, last=1; FSM stays IDLE.
- 16-bit chained add: req1 beats (0xFF,0x01,last=0) then (0x00,0x00,last=1) -> sums 0x00 (cout=1), then 0x01 (cout=0); busy=1 between the two beats.
- Subtract: req0 sub=1, a=0x05, b=0x07, last=1 -> sum=0xFE, cout=0 (borrow). Second case a=0x07, b=0x05 -> sum=0x02, cout=1.
- Arbitration: both valid in IDLE, rr_ptr=0, single-beat ops held valid -> grants alternate 0,1,0,1. A 3-beat req0 op blocks req1 (req_ready[1]=0) until req0's last beat.
- Backpressure: rsp_ready=0 for 3 cycles with a result pending -> req_ready=0, rsp_* stable. rsp_ready=1 -> drain and new accept occur in the same cycle.
- Watchdog/reset: MAX_BEATS=4 with last never asserted -> 4th rsp has ovf=1 and FSM returns to IDLE. Separately, rst_n low mid-lock -> all outputs 0 asynchronously, and the first beat after reset has cin=0.
